piano_note_sequencer: RTL

- Control block between debounced inputs and tone generator: arbitrates the 7 note switches to one sounding note and owns the octave register.
- Records a take of (note, octave, duration) events in LIVE mode and plays the take back in PLAYBACK mode.
- Runs on one clock; durations are timed by a 1-cycle tick strobe from the clocks block.

---
 rtl/piano_pkg.sv | 26 ++
 rtl/piano_take_buffer.sv | 22 ++
 rtl/piano_note_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano note sequencer: note indices, mode states
// and the take-entry layout helper.
package piano_pkg;

   localparam int NOTE_W = 3;

   localparam logic [NOTE_W-1:0] NOTE_C = 3'd0;
   localparam logic [NOTE_W-1:0] NOTE_D = 3'd1;
   localparam logic [NOTE_W-1:0] NOTE_E = 3'd2;
   localparam logic [NOTE_W-1:0] NOTE_F = 3'd3;
   localparam logic [NOTE_W-1:0] NOTE_G = 3'd4;
   localparam logic [NOTE_W-1:0] NOTE_A = 3'd5;
   localparam logic [NOTE_W-1:0] NOTE_B = 3'd6;

   typedef enum logic [1:0] {
      LIVE     = 2'd0,
      PB_FETCH = 2'd1,
      PB_PLAY  = 2'd2
   } mode_e;

   // Entry layout, MSB first: {note_on, note_idx, octave, dur}
   function automatic int entry_w(input int oct_w, input int dur_w);
      return 1 + NOTE_W + oct_w + dur_w;
   endfunction

endpackage

// File: rtl/piano_take_buffer.sv
// Take storage: single write port, registered synchronous read, no content reset
// (entry validity is tracked by the sequencer's record count).
module piano_take_buffer #(
   parameter int DEPTH = 16,
   parameter int W     = 15
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/piano_note_sequencer.sv
// Note arbitration, octave register and take record/playback between the
// debounced switches and the tone generator.
module piano_note_sequencer
   import piano_pkg::*;
#(
   parameter int NUM_NOTES   = 7,
   parameter int OCT_W       = 3,
   parameter int OCT_DEFAULT = 4,
   parameter int OCT_MIN     = 1,
   parameter int OCT_MAX     = 7,
   parameter int DEPTH       = 16,
   parameter int DUR_W       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [NUM_NOTES-1:0]     note_sw,
   input  logic                     toggle_pb,
   input  logic                     inc_octave,
   input  logic                     dec_octave,
   output logic                     note_on,
   output logic [NOTE_W-1:0]        note_idx,
   output logic [OCT_W-1:0]         octave,
   output logic                     pb_mode,
   output logic [$clog2(DEPTH):0]   rec_count,
   output logic                     rec_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_w(OCT_W, DUR_W);
   localparam logic [OCT_W-1:0] OCT_RST = OCT_W'(OCT_DEFAULT);
   localparam logic [OCT_W-1:0] OCT_LO  = OCT_W'(OCT_MIN);
   localparam logic [OCT_W-1:0] OCT_HI  = OCT_W'(OCT_MAX);
   localparam logic [DUR_W-1:0] DUR_SAT = '1;
   localparam logic [CW-1:0]    FULL_M1 = CW'(DEPTH - 1);

   mode_e                 state;
   logic [NUM_NOTES-1:0]  prev_sw;
   logic [DUR_W-1:0]      dur;
   logic                  started;
   logic [OCT_W-1:0]      live_oct;
   logic [AW-1:0]         rd_ptr;
   logic [DUR_W-1:0]      pb_cnt;
   logic                  loaded;

   logic [NUM_NOTES-1:0]  rise;
   logic                  lv_on;
   logic [NOTE_W-1:0]     lv_idx;
   logic [OCT_W-1:0]      lv_oct;
   logic [DUR_W-1:0]      d_eff;
   logic                  evt_chg, wr_ok, enter, wr_en, last_entry, pb_exit;
   logic [EW-1:0]         wr_data, rd_data;
   logic                  e_on;
   logic [NOTE_W-1:0]     e_idx;
   logic [OCT_W-1:0]      e_oct;
   logic [DUR_W-1:0]      e_dur;

   function automatic logic [NOTE_W-1:0] lowest(input logic [NUM_NOTES-1:0] v);
      lowest = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--)
         if (v[i]) lowest = NOTE_W'(i);
   endfunction

   assign wr_data = {note_on, note_idx, octave, d_eff};
   assign e_dur   = rd_data[DUR_W-1:0];
   assign e_oct   = rd_data[DUR_W +: OCT_W];
   assign e_idx   = rd_data[DUR_W+OCT_W +: NOTE_W];
   assign e_on    = rd_data[EW-1];

   always_comb begin
      rise   = note_sw & ~prev_sw;
      lv_on  = note_on;
      lv_idx = note_idx;
      if (|rise) begin
         lv_on  = 1'b1;
         lv_idx = lowest(rise);
      end else if (note_on && !note_sw[note_idx]) begin
         // active note released: fall back to the lowest switch still held
         lv_on = |note_sw;
         if (|note_sw) lv_idx = lowest(note_sw);
      end
      lv_oct = octave;
      if (inc_octave && !dec_octave && octave < OCT_HI)
         lv_oct = octave + 1'b1;
      else if (dec_octave && !inc_octave && octave > OCT_LO)
         lv_oct = octave - 1'b1;
      d_eff      = dur + DUR_W'(tick);
      evt_chg    = (lv_on != note_on) || (lv_idx != note_idx) || (lv_oct != octave);
      wr_ok      = started && (d_eff != '0) && !rec_full;
      enter      = toggle_pb && ((rec_count != '0) || wr_ok);
      wr_en      = (state == LIVE) && wr_ok && (enter || evt_chg || d_eff == DUR_SAT);
      last_entry = ({1'b0, rd_ptr} + CW'(1)) == rec_count;
      pb_exit    = (state != LIVE) &&
                   (toggle_pb ||
                    (state == PB_PLAY && loaded && tick &&
                     (pb_cnt + 1'b1) == e_dur && last_entry));
   end

   piano_take_buffer #(.DEPTH(DEPTH), .W(EW)) u_take (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (rec_count[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LIVE;
         note_on   <= 1'b0;
         note_idx  <= '0;
         octave    <= OCT_RST;
         live_oct  <= OCT_RST;
         pb_mode   <= 1'b0;
         rec_count <= '0;
         rec_full  <= 1'b0;
         prev_sw   <= '0;
         dur       <= '0;
         started   <= 1'b0;
         rd_ptr    <= '0;
         pb_cnt    <= '0;
         loaded    <= 1'b0;
      end else if (pb_exit) begin
         // take is discarded; held switches are absorbed so they do not retrigger
         state     <= LIVE;
         pb_mode   <= 1'b0;
         note_on   <= 1'b0;
         octave    <= live_oct;
         rec_count <= '0;
         rec_full  <= 1'b0;
         prev_sw   <= note_sw;
         started   <= 1'b0;
         dur       <= '0;
      end else begin
         if (wr_en) begin
            rec_count <= rec_count + 1'b1;
            rec_full  <= (rec_count == FULL_M1);
         end
         case (state)
            LIVE: begin
               if (enter) begin
                  state    <= PB_FETCH;
                  pb_mode  <= 1'b1;
                  live_oct <= octave;
                  rd_ptr   <= '0;
                  dur      <= '0;
               end else begin
                  note_on  <= lv_on;
                  note_idx <= lv_idx;
                  octave   <= lv_oct;
                  prev_sw  <= note_sw;
                  started  <= started | lv_on;
                  if (evt_chg || d_eff == DUR_SAT) dur <= '0;
                  else                             dur <= d_eff;
               end
            end
            PB_FETCH: begin
               state  <= PB_PLAY;
               loaded <= 1'b0;
            end
            PB_PLAY: begin
               // first cycle only latches the entry; ticks count once it is audible
               if (!loaded) begin
                  note_on  <= e_on;
                  note_idx <= e_idx;
                  octave   <= e_oct;
                  pb_cnt   <= '0;
                  loaded   <= 1'b1;
               end else if (tick) begin
                  if ((pb_cnt + 1'b1) == e_dur) begin
                     rd_ptr <= rd_ptr + 1'b1;
                     state  <= PB_FETCH;
                  end else begin
                     pb_cnt <= pb_cnt + 1'b1;
                  end
               end
            end
            default: state <= LIVE;
         endcase
      end
   end

endmodule
